// File: rtl/fp_op_sequencer.sv
// Issue controller in front of the FP add/subtract unit.
// Requests are queued in a small FIFO. The head is popped in IDLE and either
// answered directly (zero/denormal or Inf/NaN operands, which the adder cannot
// handle because it always forces the hidden bit) or issued to the adder. The
// result is then presented on a valid/ready port. One operation is in flight
// at a time, so results leave in request order.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a queued request; pops and classifies the head
// S_ISSUE | one-cycle add_start pulse, loads latency and timeout counters
// S_WAIT  | operands held stable, waiting for add_done or the timeout
// S_OUT   | result presented on res_*, held until res_ready
module fp_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int LAT     = 1,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_op1,
   input  logic [31:0] in_op2,
   input  logic        in_mode,
   output logic        add_start,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic        mode,
   input  logic        add_done,
   input  logic [31:0] add_result,
   input  logic        add_overflow,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_ovf,
   output logic        res_err,
   output logic        busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = $clog2(LAT + 1) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state, state_d;

   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic        mem_m [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, push, pop;

   logic [31:0] head_a, head_b;
   logic        head_m;
   logic [7:0]  exp_a, exp_b;

   logic [31:0] op1_q, op2_q;
   logic        mode_q;
   logic [31:0] res_data_q, res_data_d;
   logic        res_ovf_q, res_ovf_d;
   logic        res_err_q, res_err_d;
   logic [WW-1:0] wcnt, wcnt_d;
   logic [TW-1:0] tcnt, tcnt_d;
   logic          lat_hit;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign push   = in_valid && !full;
   assign pop    = (state == S_IDLE) && !empty;

   assign head_a = mem_a[rd_ptr];
   assign head_b = mem_b[rd_ptr];
   assign head_m = mem_m[rd_ptr];
   assign exp_a  = head_a[30:23];
   assign exp_b  = head_b[30:23];

   // wcnt is loaded with LAT in the issue cycle, so the adder result lands in
   // the WAIT cycle where wcnt has reached 1 (or already 0 for longer waits).
   assign lat_hit = (wcnt <= WW'(1));

   // FIFO storage; op2 is stored with the subtraction sign flip already applied.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= in_op1;
         mem_b[wr_ptr] <= {in_op2[31] ^ in_mode, in_op2[30:0]};
         mem_m[wr_ptr] <= in_mode;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Next-state and result-register logic.
   always_comb begin
      state_d    = state;
      res_data_d = res_data_q;
      res_ovf_d  = res_ovf_q;
      res_err_d  = res_err_q;
      wcnt_d     = wcnt;
      tcnt_d     = tcnt;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               state_d   = S_OUT;
               res_ovf_d = 1'b0;
               res_err_d = 1'b0;
               if (exp_a == 8'hFF || exp_b == 8'hFF) begin
                  res_data_d = QNAN;
                  res_err_d  = 1'b1;
               end else if (exp_a == 8'h00 && exp_b == 8'h00) begin
                  res_data_d = 32'h0000_0000;
               end else if (exp_a == 8'h00) begin
                  res_data_d = head_b;
               end else if (exp_b == 8'h00) begin
                  res_data_d = head_a;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wcnt_d  = WW'(LAT);
            tcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wcnt_d = (wcnt != '0) ? wcnt - 1'b1 : '0;
            tcnt_d = tcnt + 1'b1;
            if (lat_hit && add_done) begin
               res_data_d = add_result;
               res_ovf_d  = add_overflow | (add_result[30:23] == 8'hFF);
               res_err_d  = 1'b0;
               state_d    = S_OUT;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               res_data_d = QNAN;
               res_ovf_d  = 1'b0;
               res_err_d  = 1'b1;
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_data_d = '0;
               res_ovf_d  = 1'b0;
               res_err_d  = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and result registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= S_IDLE;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         res_err_q  <= 1'b0;
         wcnt       <= '0;
         tcnt       <= '0;
      end else begin
         state      <= state_d;
         res_data_q <= res_data_d;
         res_ovf_q  <= res_ovf_d;
         res_err_q  <= res_err_d;
         wcnt       <= wcnt_d;
         tcnt       <= tcnt_d;
      end
   end

   // Adder operand registers change only when the head is popped.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         op1_q  <= '0;
         op2_q  <= '0;
         mode_q <= 1'b0;
      end else if (pop) begin
         op1_q  <= head_a;
         op2_q  <= head_b;
         mode_q <= head_m;
      end
   end

   assign add_start = (state == S_ISSUE);
   assign op1       = op1_q;
   assign op2       = op2_q;
   assign mode      = mode_q;
   assign res_valid = (state == S_OUT);
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;
   assign res_err   = res_err_q;
   assign in_ready  = !full;
   assign busy      = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Bench for fp_op_sequencer: a simple adder model answers add_start after LAT
// cycles, and a queue of expected results (computed from the operand rules at
// push time) is compared against the DUT every cycle.
module tb_fp_op_sequencer;

   localparam int DEPTH   = 4;
   localparam int LAT     = 1;
   localparam int TIMEOUT = 16;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_op1 = '0;
   logic [31:0] in_op2 = '0;
   logic        in_mode = 1'b0;
   logic        add_start;
   logic [31:0] op1, op2;
   logic        mode;
   logic        add_done;
   logic [31:0] add_result;
   logic        add_overflow;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic        res_ovf;
   logic        res_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fp_op_sequencer #(.DEPTH(DEPTH), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_mode(in_mode),
      .add_start(add_start), .op1(op1), .op2(op2), .mode(mode),
      .add_done(add_done), .add_result(add_result), .add_overflow(add_overflow),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ovf(res_ovf), .res_err(res_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- adder model ----------------
   logic adder_en = 1'b1;
   int   dcnt;

   function automatic logic [31:0] bench_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
      if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
      r = a + {b[7:0], b[31:8]};
      if (a[3:0] == 4'hF) r[30:23] = 8'hFF;
      return r;
   endfunction

   function automatic logic bench_ovf(input logic [31:0] a, input logic [31:0] b);
      return a[4] ^ b[5];
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) dcnt <= 0;
      else if (add_start && adder_en) dcnt <= LAT;
      else if (dcnt != 0) dcnt <= dcnt - 1;
   end
   assign add_done     = (dcnt == 1);
   assign add_result   = bench_add(op1, op2);
   assign add_overflow = bench_ovf(op1, op2);

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] e2;
      logic        m;
      logic        adder;
      logic [31:0] data;
      logic        ovf;
      logic        err;
      int          lat;
   } exp_t;

   exp_t q[$];

   function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b, input logic m);
      exp_t e;
      e.a = a; e.e2 = {b[31] ^ m, b[30:0]}; e.m = m;
      e.adder = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 0; e.data = '0;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         e.data = QNAN; e.err = 1'b1;
      end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
         e.data = 32'h0;
      end else if (a[30:23] == 8'h00) begin
         e.data = e.e2;
      end else if (b[30:23] == 8'h00) begin
         e.data = a;
      end else begin
         e.adder = 1'b1;
         if (adder_en) begin
            e.data = bench_add(a, e.e2);
            e.ovf  = bench_ovf(a, e.e2) | (e.data[30:23] == 8'hFF);
            e.lat  = LAT + 1;
         end else begin
            e.data = QNAN; e.err = 1'b1;
            e.lat  = TIMEOUT + 1;
         end
      end
      return e;
   endfunction

   // ---------------- compare process ----------------
   int cyc = 0;
   int issue_cyc = 0;
   int issue_lat = 0;
   bit issued = 0;
   int start_cnt = 0;
   int res_cnt = 0;

   always @(negedge clk) begin
      if (!n_rst) begin
         issued = 0;
      end else begin
         cyc++;
         chk("busy", busy, (q.size() != 0));
         if (add_start) begin
            start_cnt++;
            if (q.size() == 0 || !q[0].adder) begin
               chk("unexpected_add_start", add_start, 1'b0);
            end else begin
               chk("issue_op1", op1, q[0].a);
               chk("issue_op2", op2, q[0].e2);
               chk("issue_mode", mode, q[0].m);
               issued = 1; issue_cyc = cyc; issue_lat = q[0].lat;
            end
         end
         if (res_valid) begin
            if (q.size() == 0) begin
               chk("spurious_res_valid", res_valid, 1'b0);
            end else begin
               chk("res_data", res_data, q[0].data);
               chk("res_ovf", res_ovf, q[0].ovf);
               chk("res_err", res_err, q[0].err);
               if (issued) begin
                  chk("issue_latency", cyc - issue_cyc, issue_lat);
                  issued = 0;
               end
               if (res_ready) begin
                  res_cnt++;
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic m);
      int n = 0;
      @(negedge clk);
      in_op1 = a; in_op2 = b; in_mode = m; in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("push_wait_in_ready", in_ready, 1'b1);
      end else begin
         @(posedge clk);
         q.push_back(make_exp(a, b, m));
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("drain_timeout", q.size(), 0);
      @(negedge clk);
   endtask

   // Push one request, watch it through, and pin the result to literals.
   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_starts, input logic [31:0] exp_op2);
      int s0 = start_cnt;
      int n = 0;
      logic [31:0] seen_op2 = '0;
      push_req(a, b, m);
      @(negedge clk);
      while (!res_valid && n < 100) begin
         if (add_start) seen_op2 = op2;
         @(negedge clk);
         n++;
      end
      chk({name, "_res_valid"}, res_valid, 1'b1);
      chk({name, "_data"}, res_data, exp_data);
      chk({name, "_err"}, res_err, exp_err);
      chk({name, "_ovf"}, res_ovf, 1'b0);
      wait_idle();
      chk({name, "_start_pulses"}, start_cnt - s0, exp_starts);
      if (exp_starts != 0) chk({name, "_op2"}, seen_op2, exp_op2);
   endtask

   function automatic logic [31:0] rand_op();
      int cls = $urandom_range(0, 9);
      logic [7:0] e;
      logic [31:0] r = $urandom();
      if (cls == 0) e = 8'h00;
      else if (cls == 1) e = 8'hFF;
      else e = 8'($urandom_range(1, 254));
      r[30:23] = e;
      return r;
   endfunction

   // ---------------- main sequence ----------------
   bit stop_ready = 0;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_res_valid", res_valid, 1'b0);
      chk("reset_add_start", add_start, 1'b0);
      n_rst = 1'b1;
      @(negedge clk);

      // directed cases
      run_one("add_1p1", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1, 32'h3F80_0000);
      run_one("sub_3m1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1, 32'hBF80_0000);
      run_one("byp_zero_a", 32'h0000_0000, 32'h4120_0000, 1'b1, 32'hC120_0000, 1'b0, 0, 32'h0);
      run_one("byp_inf", 32'h7F80_0000, 32'h3F80_0000, 1'b0, QNAN, 1'b1, 0, 32'h0);
      run_one("byp_both_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0, 32'h0);
      run_one("byp_zero_b", 32'h4120_0000, 32'h0000_0001, 1'b1, 32'h4120_0000, 1'b0, 0, 32'h0);

      // timeout
      adder_en = 1'b0;
      run_one("timeout", 32'h3F80_0000, 32'h4000_0000, 1'b0, QNAN, 1'b1, 1, 32'h4000_0000);
      adder_en = 1'b1;

      // fill the FIFO with results held back
      begin
         int r0;
         @(posedge clk); #1 res_ready = 1'b0;
         r0 = res_cnt;
         push_req(32'h3F80_0000, 32'h3F80_0000, 1'b0);
         push_req(32'h0000_0000, 32'h4120_0000, 1'b0);
         push_req(32'h4040_0000, 32'h3F80_0000, 1'b1);
         push_req(32'h7F80_0000, 32'h3F80_0000, 1'b0);
         push_req(32'h4120_0000, 32'h0000_0000, 1'b1);
         @(negedge clk);
         chk("full_in_ready", in_ready, 1'b0);
         chk("full_queued", q.size(), 5);
         @(posedge clk); #1 res_ready = 1'b1;
         wait_idle();
         chk("full_results_returned", res_cnt - r0, 5);
      end

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 80; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               push_req(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            end
            stop_ready = 1;
         end
         begin
            while (!stop_ready) begin
               @(posedge clk);
               #1 res_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1 res_ready = 1'b1;
         end
      join
      wait_idle();

      // reset while an operation waits and two more are queued
      adder_en = 1'b0;
      begin
         int rv_seen = 0;
         push_req(32'h3F80_0000, 32'h4000_0000, 1'b0);
         push_req(32'h4040_0000, 32'h4000_0000, 1'b1);
         push_req(32'h4080_0000, 32'h4000_0000, 1'b0);
         repeat (3) @(negedge clk);
         chk("pre_reset_busy", busy, 1'b1);
         n_rst = 1'b0;
         #1;
         q.delete();
         chk("rst_in_ready", in_ready, 1'b1);
         chk("rst_busy", busy, 1'b0);
         chk("rst_add_start", add_start, 1'b0);
         chk("rst_op1", op1, 32'h0);
         chk("rst_op2", op2, 32'h0);
         chk("rst_mode", mode, 1'b0);
         chk("rst_res_valid", res_valid, 1'b0);
         chk("rst_res_data", res_data, 32'h0);
         chk("rst_res_ovf", res_ovf, 1'b0);
         chk("rst_res_err", res_err, 1'b0);
         @(negedge clk);
         n_rst = 1'b1;
         adder_en = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid || add_start) rv_seen++;
         end
         chk("post_reset_no_activity", rv_seen, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got time %0t expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
